// File: rtl/pong_pkg.sv
// Shared Pong board constants: button indices, default input timing, lane state type.
package pong_pkg;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

  // Cycle counts at the 12.5 MHz game clock.
  localparam int unsigned DEBOUNCE_20MS       = 250000;
  localparam int unsigned REPEAT_DELAY_500MS  = 6250000;
  localparam int unsigned REPEAT_PERIOD_100MS = 1250000;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } lane_state_t;

endpackage

// File: rtl/debounce_lane.sv
// One button lane: 2-flop synchronizer, debounce counter, IDLE/HELD FSM, press/release pulses.
// Optional auto-repeat timer built only when BTN_AUTO_REPEAT_EN is defined.
//   state | meaning
//   IDLE  | debounced level low, waiting for a stable press
//   HELD  | debounced level high, waiting for a stable release
module debounce_lane
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_d;
  lane_state_t   state, state_d;
  logic          press_d, rel_d;
  logic          mismatch;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX) + 1;
  logic [RW-1:0] rpt, rpt_d;
`endif

  assign mismatch  = s2 != (state == HELD);
  assign btn_level = (state == HELD);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d = cnt + 1'b1;
    end else begin
      cnt_d = '0;
      if (state == IDLE) begin
        state_d = HELD;
        press_d = 1'b1;
      end else begin
        state_d = IDLE;
        rel_d   = 1'b1;
      end
    end
`ifdef BTN_AUTO_REPEAT_EN
    // Down-counter reloads on each fire; release wins over a repeat in the same cycle.
    rpt_d = '0;
    if (press_d) begin
      rpt_d = RW'(REPEAT_DELAY - 1);
    end else if (state == HELD && !rel_d) begin
      if (rpt == '0) begin
        press_d = 1'b1;
        rpt_d   = RW'(REPEAT_PERIOD - 1);
      end else begin
        rpt_d = rpt - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt         <= '0;
`endif
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      state       <= state_d;
      cnt         <= cnt_d;
      btn_press   <= press_d;
      btn_release <= rel_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt         <= rpt_d;
`endif
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the Pong push-buttons into clean levels and press/release pulses.
// Auto-repeat on held buttons is enabled by defining BTN_AUTO_REPEAT_EN.
module button_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_lane
    debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_button_conditioner;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release;
  int         total = 0;
  int         bad = 0;

  button_conditioner #(
    .NUM_BTNS        (5),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 5'b11111;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({btn_level, btn_press, btn_release} !== 15'b0) begin
        bad++;
        $display("FAIL reset_during k=%0d got lvl=%b prs=%b rel=%b want all 0", k, btn_level, btn_press, btn_release);
      end
    end
    reset   = 1'b0;
    btn_raw = 5'b00000;
    step();
    total++;
    if ({btn_level, btn_press, btn_release} !== 15'b0) begin
      bad++;
      $display("FAIL reset_after got lvl=%b prs=%b rel=%b want all 0", btn_level, btn_press, btn_release);
    end
  endtask

  // Lane U rises and stays high: level and press at +10, press gone at +11.
  task automatic test_press();
    logic [4:0] el, ep;
    btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00001 : 5'b00000;
      ep = (k == 10) ? 5'b00001 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b00000}) begin
        bad++;
        $display("FAIL press k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
  endtask

  // Lane D bounces with glitches shorter than the debounce window, then a real press and release.
  task automatic test_bounce();
    int   seg_len [4] = '{5, 1, 5, 12};
    logic seg_val [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] el, ep, er;
    for (int s = 0; s < 4; s++) begin
      btn_raw[BTN_D] = seg_val[s];
      for (int k = 0; k < seg_len[s]; k++) begin
        step();
        total++;
        if ({btn_level, btn_press, btn_release} !== {5'b00001, 5'b00000, 5'b00000}) begin
          bad++;
          $display("FAIL bounce seg=%0d k=%0d got lvl=%b prs=%b rel=%b want lvl=00001 prs=00000 rel=00000",
                   s, k, btn_level, btn_press, btn_release);
        end
      end
    end
    btn_raw[BTN_D] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      el = (k >= 10) ? 5'b00011 : 5'b00001;
      ep = (k == 10) ? 5'b00010 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b00000}) begin
        bad++;
        $display("FAIL bounce_hold k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw[BTN_D] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00001 : 5'b00011;
      er = (k == 10) ? 5'b00010 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, 5'b00000, er}) begin
        bad++;
        $display("FAIL bounce_release k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=00000 rel=%b",
                 k, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  // Lane L pressed, then lanes L and U released in the same cycle: simultaneous release pulses.
  task automatic test_release();
    logic [4:0] el, ep, er;
    btn_raw[BTN_L] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00101 : 5'b00001;
      ep = (k == 10) ? 5'b00100 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b00000}) begin
        bad++;
        $display("FAIL release_setup k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw[BTN_L] = 1'b0;
    btn_raw[BTN_U] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00000 : 5'b00101;
      er = (k == 10) ? 5'b00101 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, 5'b00000, er}) begin
        bad++;
        $display("FAIL release k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=00000 rel=%b",
                 k, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  // Reset mid-count on lane U discards the pending press; press lands 10 cycles after release of reset.
  task automatic test_reset_mid();
    logic [4:0] el, ep, er;
    btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if ({btn_level, btn_press, btn_release} !== 15'b0) begin
        bad++;
        $display("FAIL reset_mid_pre k=%0d got lvl=%b prs=%b rel=%b want all 0", k, btn_level, btn_press, btn_release);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({btn_level, btn_press, btn_release} !== 15'b0) begin
      bad++;
      $display("FAIL reset_mid_in got lvl=%b prs=%b rel=%b want all 0", btn_level, btn_press, btn_release);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00001 : 5'b00000;
      ep = (k == 10) ? 5'b00001 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b00000}) begin
        bad++;
        $display("FAIL reset_mid_post k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw[BTN_U] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      el = (k >= 10) ? 5'b00000 : 5'b00001;
      er = (k == 10) ? 5'b00001 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, 5'b00000, er}) begin
        bad++;
        $display("FAIL reset_mid_rel k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=00000 rel=%b",
                 k, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  // Lane R held long: press at +10, repeats at +30,+35,.. only with auto-repeat, release at +52.
  task automatic test_repeat();
    logic [4:0] el, ep, er;
    logic       rep;
    btn_raw[BTN_R] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
`ifdef BTN_AUTO_REPEAT_EN
      rep = (k >= 30) && (k < 52) && ((k - 30) % 5 == 0);
`else
      rep = 1'b0;
`endif
      el = (k >= 10 && k < 52) ? 5'b01000 : 5'b00000;
      ep = (k == 10 || rep) ? 5'b01000 : 5'b00000;
      er = (k == 52) ? 5'b01000 : 5'b00000;
      total++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, er}) begin
        bad++;
        $display("FAIL repeat k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                 k, btn_level, btn_press, btn_release, el, ep, er);
      end
      if (k == 42) btn_raw[BTN_R] = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 5'b00000;
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
